wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Shares one Wishbone classic slave port (system RAM/ROM/IO decoder) between several bus masters: the Z80 bus wrapper, the video fetch engine and DMA/FDC engines. Master 0 has fixed top priority for raster fetch, and the remaining masters share the bus round-robin. A grant is held for the whole `cyc` window, so read-modify-write and multi-beat accesses stay atomic. An optional watchdog terminates accesses that the slave never acknowledges.

## Interface
- `NUM_MASTERS`, 3: number of masters; legal range 2..8. Index 0 is the fixed-priority master.
- `ADDR_W`, 24: Wishbone address width.
- `DATA_W`, 8: Wishbone data width; `sel` is 1 bit.
- `TIMEOUT_CYC`, 255: watchdog limit in cycles (only with the macro); legal range 2..65535.

- `CLK`  in  1  system clock; all logic on rising edge.
- `nRESET`  in  1  asynchronous reset, active-high.
- `m_cyc_i`, `m_stb_i`, `m_we_i`, `m_sel_i`  in  NUM_MASTERS each  per-master request and strobe signals.
- `m_adr_i`  in  NUM_MASTERS*ADDR_W  per-master address, packed; master k occupies `[k*ADDR_W +: ADDR_W]`.
- `m_dat_i`  in  NUM_MASTERS*DATA_W  per-master write data, packed in the same way.
- `m_ack_o`  out  NUM_MASTERS  per-master acknowledge.
- `m_err_o`  out  NUM_MASTERS  per-master watchdog error; tied 0 without the macro.
- `m_dat_o`  out  DATA_W  read data, broadcast to all masters; valid only with the recipient's own `m_ack_o`.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_sel_o`  out  1 each  slave-side control.
- `s_adr_o`  out  ADDR_W  slave-side address.
- `s_dat_o`  out  DATA_W  slave-side write data.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  DATA_W  slave read data.
- `grant_o`  out  $clog2(NUM_MASTERS)  index of the current owner; meaningful while `busy_o` is high.
- `busy_o`  out  1  high while the arbiter is in state BUSY.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine: IDLE and BUSY, plus TERM only with the macro.
- IDLE
  - If any `m_cyc_i` bit is high, the arbiter registers the winner into `grant_o` and moves to BUSY.
  - Winner: master 0 if it requests; otherwise the first requester at or after `rr_ptr`, searching 1..NUM_MASTERS-1 with wrap.
  - After granting master k≥1, `rr_ptr` becomes k+1, wrapping NUM_MASTERS to 1. Granting master 0 leaves `rr_ptr` unchanged.
- BUSY
  - Slave outputs combinationally mirror the granted master's `cyc`/`stb`/`we`/`sel`/`adr`/`dat`.
  - `m_ack_o[grant] = s_ack_i`; every other `m_ack_o` bit is 0.
  - `m_dat_o = s_dat_i`.
  - If the granted `m_cyc_i` is low, the arbiter returns to IDLE; in that same cycle `s_cyc_o`/`s_stb_o` are already low, because they mirror the master.
  - A master holding `cyc` across several `stb` beats keeps the grant; there is no preemption, including by master 0.
- Requests from non-granted masters are ignored and never acknowledged while they wait.
- Outside BUSY, all `s_*` outputs, `m_ack_o` and `m_dat_o` are 0.
- Reset values: state IDLE; `rr_ptr` = 1; `grant_o` = 0; `busy_o` = 0; `timeout_o` = 0. All other outputs are 0, since they are combinational from state.
- Reset asserted mid-access: the bus is released immediately (asynchronously), with no ack to the owner. After reset, arbitration restarts from `rr_ptr` = 1.

## Timing
- Grant latency: `m_cyc_i` high before edge N gives `s_cyc_o` high during cycle N (after edge N).
- Ack path: zero-cycle combinational pass-through.
- Release: one dead IDLE cycle between consecutive owners. A master that re-asserts `cyc` immediately re-arbitrates normally.
- Simultaneous requests from masters 0, 1 and 2 produce grants in the order 0, 1, 2. If 0 and 1 then re-request, the order continues 0, 2 (if still pending), then 1.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A 16-bit counter clears whenever `s_stb_o` is low or `s_ack_i` is high, and increments otherwise in BUSY.
  - When the count reaches TIMEOUT_CYC-1 with no ack, then in that cycle: `m_ack_o[grant]` = 1, `m_err_o[grant]` = 1, `m_dat_o` = all ones, `timeout_o` = 1, `s_stb_o` is forced to 0.
  - The FSM then enters TERM. In TERM, slave outputs are forced low and the FSM returns to IDLE once the granted `m_cyc_i` drops.
- Without the macro: no counter, no TERM state, `m_err_o` and `timeout_o` tied 0, and a stalled slave holds the bus indefinitely.

## Structure
- Package `wb_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY, TERM);
  - the `MAX_MASTERS`=8 constant;
  - the `next_rr(ptr, n)` wrap function.
- Sub-module `wb_arb_rr_pick`: combinational picker. Inputs are the request vector and `rr_ptr`; outputs are the winner index and a valid flag. It implements the master-0 priority plus the round-robin search. Packed-bus muxing stays in the top module.

## Test plan
- Single master: master 1 reads 0x00C000 while the slave acks 2 cycles after `stb` with 0x5A. Required: `s_cyc_o` high 1 cycle after request; master 1 gets ack with `m_dat_o`=0x5A; `m_ack_o[0]` and `m_ack_o[2]` stay 0.
- Priority: masters 0, 1 and 2 request in the same cycle. Required: `grant_o` sequence 0, 1, 2, with one IDLE cycle between owners.
- Round-robin fairness: masters 1 and 2 request continuously for 8 accesses. Required: grants alternate 1, 2, 1, 2…, with no starvation.
- Lock: master 2 holds `cyc` over a read then a write to 0x00BFFF while master 0 requests. Required: master 0 is not granted until master 2 drops `cyc`.
- Watchdog (with `WB_ARB_TIMEOUT_EN`, TIMEOUT_CYC=16): slave never acks. Required: in cycle 16 of the strobe, `m_ack_o`, `m_err_o` and `timeout_o` each pulse for 1 cycle and `m_dat_o`=0xFF.
- Reset during an access: assert `nRESET` while master 1 is mid-write. Required: all `s_*` outputs go to 0 immediately; after release, the first grant follows priority order from `rr_ptr`=1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg -- shared types and helpers for the Wishbone bus arbiter.
//   arb_state_t : arbiter FSM states (TERM only reachable with WB_ARB_TIMEOUT_EN)
//   MAX_MASTERS : upper bound on the number of masters
//   IDX_W       : width of a master index at MAX_MASTERS
//   next_rr()   : advance the round-robin pointer, wrapping n back to 1
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TERM = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;

    // Master 0 never takes part in the rotation, so the pointer lives in 1..n-1.
    function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] ptr,
                                                 input int unsigned       n);
        if (32'(ptr) + 32'd1 >= n)
            return IDX_W'(1);
        else
            return ptr + IDX_W'(1);
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick -- combinational winner selection for wb_bus_arbiter.
//   req    : request vector, one bit per master
//   rr_ptr : first round-robin candidate (1..NUM_MASTERS-1)
//   winner : index of the selected master
//   valid  : at least one request is present
// Master 0 always wins when requesting; otherwise the first requester at or
// after rr_ptr wins, wrapping around to master 1.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    localparam int unsigned GW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GW-1:0]          rr_ptr,
    output logic [GW-1:0]          winner,
    output logic                   valid
);

    logic          hi_hit;
    logic [GW-1:0] hi_idx;
    logic          lo_hit;
    logic [GW-1:0] lo_idx;

    // Two scans replace a modulo rotation: hi finds the first requester at or
    // above rr_ptr, lo the first requester overall; lo covers the wrap case.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_hit = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (req[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = GW'(i);
            end
            if (req[i] && !hi_hit && (i >= 32'(rr_ptr))) begin
                hi_hit = 1'b1;
                hi_idx = GW'(i);
            end
        end
    end

    always_comb begin
        valid = |req;
        if (req[0])
            winner = '0;
        else if (hi_hit)
            winner = hi_idx;
        else
            winner = lo_idx;
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter -- shares one Wishbone classic slave port between masters.
// Master 0 has fixed top priority (raster fetch); masters 1..N-1 rotate.
// The grant is held for the whole cyc window, keeping RMW/multi-beat atomic.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN -- watchdog that terminates an
// access the slave never acknowledges (ack + err + all-ones data, then TERM).
//
// Ports:
//   CLK, nRESET         clock; asynchronous active-high reset
//   m_cyc_i..m_sel_i    per-master control, one bit per master
//   m_adr_i, m_dat_i    per-master address / write data, packed by index
//   m_ack_o, m_err_o    per-master acknowledge / watchdog error
//   m_dat_o             read data broadcast to all masters
//   s_*_o, s_*_i        slave-side Wishbone port
//   grant_o, busy_o     current owner index, BUSY-state flag
//   timeout_o           one-cycle pulse when the watchdog fires
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned GW = $clog2(NUM_MASTERS)
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_sel_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [DATA_W-1:0]             m_dat_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic                          s_sel_o,
    output logic [ADDR_W-1:0]             s_adr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    input  logic                          s_ack_i,
    input  logic [DATA_W-1:0]             s_dat_i,
    output logic [GW-1:0]                 grant_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    // Parameter range sanity flag; nothing downstream consumes it.
    localparam bit CFG_OK = (NUM_MASTERS >= 2) && (NUM_MASTERS <= MAX_MASTERS) &&
                            (TIMEOUT_CYC >= 2) && (TIMEOUT_CYC <= 65535);
    logic unused_cfg_ok;
    assign unused_cfg_ok = CFG_OK;

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          rr_ptr_q;
    logic [GW-1:0]          pick_win;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] grant_oh;

    // Signals of the granted master, selected from the packed buses.
    logic              g_cyc;
    logic              g_stb;
    logic              g_we;
    logic              g_sel;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;

    wb_arb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req    (m_cyc_i),
        .rr_ptr (rr_ptr_q),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = 1'b0;
        g_adr = '0;
        g_dat = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (GW'(k) == grant_q) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_sel = m_sel_i[k];
                g_adr = m_adr_i[k*ADDR_W +: ADDR_W];
                g_dat = m_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_oh = NUM_MASTERS'(1) << grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q;
    logic        wd_fire;

    // Counts the master's stb cycles without ack; the raw stb is used so the
    // forced-low stb in the firing cycle does not feed back into the count.
    assign wd_fire = (state_q == BUSY) && g_stb && !s_ack_i &&
                     (wd_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge nRESET) begin
        if (nRESET)
            wd_cnt_q <= '0;
        else if ((state_q == BUSY) && g_stb && !s_ack_i)
            wd_cnt_q <= wd_cnt_q + 16'd1;
        else
            wd_cnt_q <= '0;
    end
`endif

    always_ff @(posedge CLK or posedge nRESET) begin
        if (nRESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(1);
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && pick_valid) begin
                grant_q <= pick_win;
                if (pick_win != '0)
                    rr_ptr_q <= GW'(next_rr(IDX_W'(pick_win), NUM_MASTERS));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = '0;
        timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid)
                    state_d = BUSY;
            end
            BUSY: begin
                // Mirroring cyc means the slave sees the release in the same
                // cycle the owner drops it, one cycle before IDLE.
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                s_we_o  = g_we;
                s_sel_o = g_sel;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                m_dat_o = s_dat_i;
                m_ack_o = s_ack_i ? grant_oh : '0;
`ifdef WB_ARB_TIMEOUT_EN
                if (wd_fire) begin
                    s_stb_o   = 1'b0;
                    m_ack_o   = grant_oh;
                    m_err_o   = grant_oh;
                    m_dat_o   = '1;
                    timeout_o = 1'b1;
                    state_d   = TERM;
                end else
`endif
                if (!g_cyc)
                    state_d = IDLE;
            end
`ifdef WB_ARB_TIMEOUT_EN
            TERM: begin
                if (!g_cyc)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == BUSY);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter -- directed self-checking bench for wb_bus_arbiter
// (3 masters, 24-bit address, 8-bit data, TIMEOUT_CYC = 16).
module tb_wb_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 24;
    localparam int DW = 8;

    logic             CLK = 1'b0;
    logic             nRESET;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_sel_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [DW-1:0]    m_dat_o;
    logic             s_cyc_o, s_stb_o, s_we_o, s_sel_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic             s_ack_i;
    logic [DW-1:0]    s_dat_i;
    logic [1:0]       grant_o;
    logic             busy_o, timeout_o;

    always #5 CLK = ~CLK;

    wb_bus_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_sel_i   (m_sel_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    // Slave: acks after ack_lat wait cycles of an open cycle.
    logic        slave_en;
    int unsigned ack_lat;
    logic [7:0]  slave_rdata;
    int unsigned wait_cnt;

    assign s_ack_i = slave_en && s_cyc_o && (wait_cnt == ack_lat);
    assign s_dat_i = slave_rdata;

    always @(posedge CLK or posedge nRESET) begin
        if (nRESET)
            wait_cnt <= 0;
        else if (s_cyc_o && !s_ack_i)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    int total = 0;
    int bad   = 0;
    int glog[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m_cyc_i[k]         = cyc;
        m_stb_i[k]         = stb;
        m_we_i[k]          = we;
        m_sel_i[k]         = cyc;
        m_adr_i[k*AW +: AW] = adr;
        m_dat_i[k*DW +: DW] = dat;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Each master performs n single-beat reads, dropping cyc for one cycle
    // after every ack; the start of every BUSY window is logged.
    task automatic run_auto(input string tag, input int n0, input int n1, input int n2,
                            input int budget);
        int         left[3];
        logic       gap[3];
        logic       prev_busy;
        logic       stray;
        logic       done;
        logic [2:0] acked;
        logic [2:0] allowed;
        left      = '{n0, n1, n2};
        gap       = '{1'b0, 1'b0, 1'b0};
        prev_busy = busy_o;
        stray     = 1'b0;
        done      = 1'b0;
        glog.delete();
        for (int c = 0; c < budget; c++) begin
            for (int k = 0; k < NM; k++)
                set_m(k, (left[k] != 0) && !gap[k], (left[k] != 0) && !gap[k], 1'b0,
                      24'h001000 + 24'(k), 8'h00);
            settle();
            if (busy_o && !prev_busy)
                glog.push_back(int'(grant_o));
            prev_busy = busy_o;
            acked     = m_ack_o;
            allowed   = busy_o ? (3'b001 << grant_o) : 3'b000;
            if ((acked & ~allowed) != 3'b000)
                stray = 1'b1;
            if (left[0] == 0 && left[1] == 0 && left[2] == 0 && !busy_o) begin
                done = 1'b1;
                break;
            end
            step();
            for (int k = 0; k < NM; k++) begin
                gap[k] = acked[k];
                if (acked[k])
                    left[k]--;
            end
        end
        chk({tag, " completes in budget"}, 32'(done), 1);
        chk({tag, " no ack to a waiting master"}, 32'(stray), 0);
    endtask

    int exp_prio[3] = '{0, 1, 2};
    int exp_fair[8] = '{1, 2, 1, 2, 1, 2, 1, 2};
    int exp_rreq[5] = '{0, 0, 1, 2, 1};

    initial begin
        nRESET      = 1'b1;
        m_cyc_i     = '0;
        m_stb_i     = '0;
        m_we_i      = '0;
        m_sel_i     = '0;
        m_adr_i     = '0;
        m_dat_i     = '0;
        slave_en    = 1'b1;
        ack_lat     = 0;
        slave_rdata = 8'h00;

        // Reset state
        #2;
        chk("reset busy", 32'(busy_o), 0);
        chk("reset grant", 32'(grant_o), 0);
        chk("reset s_cyc", 32'(s_cyc_o), 0);
        chk("reset m_ack", 32'(m_ack_o), 0);
        chk("reset timeout", 32'(timeout_o), 0);
        #10 nRESET = 1'b0;
        step();

        // Priority: 0, 1, 2 request together
        run_auto("prio", 1, 1, 1, 60);
        chk("prio grant count", 32'(glog.size()), 3);
        for (int i = 0; i < 3; i++)
            if (i < glog.size())
                chk($sformatf("prio grant %0d", i), 32'(glog[i]), 32'(exp_prio[i]));

        // Round-robin fairness between 1 and 2
        run_auto("fair", 0, 4, 4, 120);
        chk("fair grant count", 32'(glog.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < glog.size())
                chk($sformatf("fair grant %0d", i), 32'(glog[i]), 32'(exp_fair[i]));

        // Re-requests: master 0 repeats first, then rotation resumes at 1
        run_auto("rreq", 2, 2, 1, 120);
        chk("rreq grant count", 32'(glog.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < glog.size())
                chk($sformatf("rreq grant %0d", i), 32'(glog[i]), 32'(exp_rreq[i]));

        // Single master: master 1 reads 0x00C000, ack after 2 wait cycles
        ack_lat     = 2;
        slave_rdata = 8'h5A;
        set_m(1, 1'b1, 1'b1, 1'b0, 24'h00C000, 8'h00);
        settle();
        chk("single no cyc before edge", 32'(s_cyc_o), 0);
        step(); settle();
        chk("single s_cyc", 32'(s_cyc_o), 1);
        chk("single grant", 32'(grant_o), 1);
        chk("single s_adr", 32'(s_adr_o), 32'h00C000);
        chk("single no early ack", 32'(m_ack_o), 0);
        step(); settle();
        chk("single wait beat", 32'(m_ack_o), 0);
        step(); settle();
        chk("single ack only m1", 32'(m_ack_o), 32'b010);
        chk("single read data", 32'(m_dat_o), 32'h5A);
        step();
        set_m(1, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        settle();
        chk("single release s_cyc", 32'(s_cyc_o), 0);
        chk("single release busy", 32'(busy_o), 1);
        step(); settle();
        chk("single idle busy", 32'(busy_o), 0);
        chk("single idle m_dat", 32'(m_dat_o), 0);

        // Lock: master 2 read+write at 0x00BFFF while master 0 waits
        ack_lat     = 1;
        slave_rdata = 8'h11;
        set_m(2, 1'b1, 1'b1, 1'b0, 24'h00BFFF, 8'h00);
        settle();
        step();
        set_m(0, 1'b1, 1'b1, 1'b0, 24'h000100, 8'h00);
        settle();
        chk("lock owner read", 32'(grant_o), 2);
        chk("lock s_adr", 32'(s_adr_o), 32'h00BFFF);
        chk("lock read wait", 32'(m_ack_o), 0);
        step(); settle();
        chk("lock read ack", 32'(m_ack_o), 32'b100);
        step();
        set_m(2, 1'b1, 1'b1, 1'b1, 24'h00BFFF, 8'hA5);
        settle();
        chk("lock owner write", 32'(grant_o), 2);
        chk("lock s_we", 32'(s_we_o), 1);
        chk("lock s_dat", 32'(s_dat_o), 32'hA5);
        step(); settle();
        chk("lock write ack", 32'(m_ack_o), 32'b100);
        step();
        set_m(2, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        settle();
        chk("lock drop still busy", 32'(busy_o), 1);
        chk("lock drop m0 not acked", 32'(m_ack_o), 0);
        step(); settle();
        chk("lock dead idle", 32'(busy_o), 0);
        step(); settle();
        chk("lock m0 granted", 32'(grant_o), 0);
        chk("lock m0 busy", 32'(busy_o), 1);
        chk("lock m0 s_adr", 32'(s_adr_o), 32'h000100);
        step(); settle();
        chk("lock m0 ack", 32'(m_ack_o), 32'b001);
        step();
        set_m(0, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        step(); settle();
        chk("lock back idle", 32'(busy_o), 0);

        slave_en = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never acks, fires in strobe cycle 16
        set_m(1, 1'b1, 1'b1, 1'b0, 24'h00D000, 8'h00);
        step();
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk($sformatf("wd timeout cyc%0d", i), 32'(timeout_o), (i == 16) ? 1 : 0);
            chk($sformatf("wd ack cyc%0d", i), 32'(m_ack_o), (i == 16) ? 32'b010 : 0);
            if (i == 16) begin
                chk("wd err", 32'(m_err_o), 32'b010);
                chk("wd data", 32'(m_dat_o), 32'hFF);
                chk("wd stb forced low", 32'(s_stb_o), 0);
            end
            step();
        end
        set_m(1, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        settle();
        chk("wd term busy", 32'(busy_o), 0);
        chk("wd term s_cyc", 32'(s_cyc_o), 0);
        chk("wd term timeout", 32'(timeout_o), 0);
        chk("wd term ack", 32'(m_ack_o), 0);
        step();
`else
        // Stalled slave: bus stays held, no error or timeout
        set_m(1, 1'b1, 1'b1, 1'b0, 24'h00D000, 8'h00);
        step();
        repeat (20) step();
        settle();
        chk("stall still busy", 32'(busy_o), 1);
        chk("stall grant", 32'(grant_o), 1);
        chk("stall s_stb", 32'(s_stb_o), 1);
        chk("stall no err", 32'(m_err_o), 0);
        chk("stall no timeout", 32'(timeout_o), 0);
        chk("stall no ack", 32'(m_ack_o), 0);
        step();
        set_m(1, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        step();
`endif
        settle();
        chk("pre-reset idle", 32'(busy_o), 0);

        // Reset during a write by master 1, master 2 waiting
        set_m(1, 1'b1, 1'b1, 1'b1, 24'h00A000, 8'h33);
        step();
        set_m(2, 1'b1, 1'b1, 1'b0, 24'h00E000, 8'h00);
        settle();
        chk("rst owner before", 32'(grant_o), 1);
        chk("rst s_we before", 32'(s_we_o), 1);
        chk("rst s_dat before", 32'(s_dat_o), 32'h33);
        nRESET = 1'b1;
        #1;
        chk("rst s_cyc", 32'(s_cyc_o), 0);
        chk("rst s_stb", 32'(s_stb_o), 0);
        chk("rst s_we", 32'(s_we_o), 0);
        chk("rst s_adr", 32'(s_adr_o), 0);
        chk("rst s_dat", 32'(s_dat_o), 0);
        chk("rst m_ack", 32'(m_ack_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        nRESET = 1'b0;
        step(); settle();
        chk("rst regrant busy", 32'(busy_o), 1);
        chk("rst regrant from ptr 1", 32'(grant_o), 1);
        slave_en = 1'b1;
        ack_lat  = 0;
        step();
        set_m(1, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        step(); step(); settle();
        chk("rst then master 2", 32'(grant_o), 2);
        step();
        set_m(2, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
